// File: rtl/matriz_pkg.sv
// matriz_pkg: shared constants and types for the LED matrix row-scan controller
package matriz_pkg;
  localparam int ROWS_DEF = 7;
  localparam int COLS_DEF = 5;
  localparam int ROW_W = 3;
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;
  typedef logic [COLS_DEF-1:0] row_t;
endpackage

// File: rtl/matriz_buffer.sv
// matriz_buffer: double-buffered frame store; back written by the decoder, front copied on swap
module matriz_buffer
  import matriz_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic             swap,
  input  logic             idle,
  input  logic             wrap,
  input  logic [ROW_W-1:0] rd_row,
  output logic [COLS-1:0]  rd_data,
  output logic             swap_ack
);
  logic [COLS-1:0] back [ROWS];
  logic [COLS-1:0] front [ROWS];
  logic pending;
  logic copy;
  // a pending swap lands only when the scan is parked or at a frame boundary, so the shown frame never tears
  always_comb begin
    copy = pending && (idle || wrap);
    rd_data = front[rd_row];
  end
  // buffers, swap request latch and ack pulse; the copy reads back before any same-edge write lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        back[i] <= '0;
        front[i] <= '0;
      end
      pending <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      if (copy) front <= back;
      if (wr && int'(wr_row) < ROWS) back[wr_row] <= wr_data;
      pending <= copy ? 1'b0 : pending || swap;
      swap_ack <= copy;
    end
  end
endmodule

// File: rtl/matriz_varredura.sv
// matriz_varredura: 7x5 LED matrix row-scan controller with blanking; define MATRIZ_PWM_EN for duty-cycle dimming
module matriz_varredura
  import matriz_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int DIV = 50000,
  parameter int BLANK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic             swap,
`ifdef MATRIZ_PWM_EN
  input  logic [2:0]       duty,
`endif
  output logic             swap_ack,
  output logic [ROWS-1:0]  l,
  output logic [COLS-1:0]  c,
  output logic             frame_end
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ROW_W-1:0] row, row_n;
  logic slot_end, wrap, restart, drive_on;
  logic [ROWS-1:0] l_n;
  logic [COLS-1:0] c_n, rd_data;
  matriz_buffer #(.ROWS(ROWS), .COLS(COLS)) u_buf (
    .clk(clk),
    .rst(rst),
    .wr(wr),
    .wr_row(wr_row),
    .wr_data(wr_data),
    .swap(swap),
    .idle(state == S_IDLE),
    .wrap(wrap),
    .rd_row(row_n),
    .rd_data(rd_data),
    .swap_ack(swap_ack)
  );
  // scan position: state, cycle within the row slot, active row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      row <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      row <= row_n;
    end
  end
  // each slot is BLANK dark cycles then DRIVE; dropping en parks the scan at row 0
  always_comb begin
    slot_end = state == S_DRIVE && cnt == SLOT_LAST;
    wrap = en && slot_end && row == ROW_LAST;
    restart = !en || state == S_IDLE;
    state_n = !en ? S_IDLE :
              state == S_IDLE ? S_BLANK :
              state == S_BLANK ? (cnt == BLANK_LAST ? S_DRIVE : S_BLANK) :
              slot_end ? S_BLANK : S_DRIVE;
    cnt_n = restart || slot_end ? '0 : cnt + 1'b1;
    row_n = restart || wrap ? '0 : slot_end ? row + 1'b1 : row;
  end
`ifdef MATRIZ_PWM_EN
  logic [2:0] pwm_cnt, pwm_n;
  // free-running brightness phase; columns conduct while the phase is at or below duty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else pwm_cnt <= pwm_n;
  end
  assign pwm_n = pwm_cnt + 3'd1;
  assign drive_on = state_n == S_DRIVE && pwm_n <= duty;
`else
  assign drive_on = state_n == S_DRIVE;
`endif
  // pin values decoded from the upcoming scan position so the registered pins track the state
  always_comb begin
    l_n = state_n == S_DRIVE ? ~(ROWS'(1) << row_n) : '1;
    c_n = drive_on ? rd_data : '0;
  end
  // registered pins and frame wrap pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l <= '1;
      c <= '0;
      frame_end <= 1'b0;
    end else begin
      l <= l_n;
      c <= c_n;
      frame_end <= wrap;
    end
  end
endmodule

// File: tb/tb_matriz_varredura.sv
// tb_matriz_varredura: directed checks of the row-scan controller with DIV=8, BLANK=2
module tb_matriz_varredura;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic wr = 1'b0;
  logic swap = 1'b0;
  logic [2:0] wr_row = 3'd0;
  logic [4:0] wr_data = 5'd0;
  logic swap_ack, frame_end;
  logic [6:0] l;
  logic [4:0] c;
  logic [4:0] cap [7];
  int n_cmp = 0;
  int n_bad = 0;
`ifdef MATRIZ_PWM_EN
  logic [2:0] duty = 3'd7;
  logic [2:0] pwm_m;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_m <= 3'd0;
    else pwm_m <= pwm_m + 3'd1;
  end
`endif
  always #5 clk = ~clk;
  matriz_varredura #(.DIV(8), .BLANK(2)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .wr(wr),
    .wr_row(wr_row),
    .wr_data(wr_data),
    .swap(swap),
`ifdef MATRIZ_PWM_EN
    .duty(duty),
`endif
    .swap_ack(swap_ack),
    .l(l),
    .c(c),
    .frame_end(frame_end)
  );
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic write_row(input logic [2:0] r, input logic [4:0] d);
    wr = 1'b1;
    wr_row = r;
    wr_data = d;
    tick();
    wr = 1'b0;
  endtask
  task automatic wait_frame(input string tag);
    int k = 0;
    while (!frame_end && k < 200) begin
      tick();
      k++;
    end
    check(tag, 7'(frame_end), 7'd1);
  endtask
  task automatic scan_frame(input string tag);
    int extra = 0;
    wait_frame(tag);
    for (int r = 0; r < 7; r++) cap[r] = 5'd0;
    for (int i = 0; i < 56; i++) begin
      for (int r = 0; r < 7; r++) if (l == ~(7'd1 << r)) cap[r] |= c;
      if (i > 0 && frame_end) extra++;
      tick();
    end
    check({tag, "_len"}, 7'(frame_end), 7'd1);
    check({tag, "_extra_fe"}, 7'(extra), 7'd0);
  endtask
  initial begin
    logic ack_early, seen6;
    logic [4:0] c6;
    int k;
    #2 rst = 1'b1;
    #1;
    check("rst_l", l, 7'h7f);
    check("rst_c", 7'(c), 7'd0);
    check("rst_ack", 7'(swap_ack), 7'd0);
    check("rst_fe", 7'(frame_end), 7'd0);
    tick(2);
    rst = 1'b0;
    tick();
    write_row(3'd0, 5'b10101);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    check("ack_pending", 7'(swap_ack), 7'd0);
    tick();
    check("ack_idle", 7'(swap_ack), 7'd1);
    tick();
    check("ack_pulse", 7'(swap_ack), 7'd0);
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("blank0_l", l, 7'h7f);
      check("blank0_c", 7'(c), 7'd0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      check("drv0_l", l, 7'b1111110);
      check("drv0_c", 7'(c), 7'b0010101);
    end
    tick();
    check("blank1_l", l, 7'h7f);
    tick(2);
    check("drv1_l", l, 7'b1111101);
    check("drv1_c", 7'(c), 7'd0);
    write_row(3'd6, 5'b01110);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    ack_early = 1'b0;
    seen6 = 1'b0;
    c6 = 5'd0;
    k = 0;
    while (!frame_end && k < 100) begin
      ack_early |= swap_ack;
      if (l == 7'b0111111) begin
        seen6 = 1'b1;
        c6 |= c;
      end
      tick();
      k++;
    end
    check("fe_first", 7'(frame_end), 7'd1);
    check("ack_at_fe", 7'(swap_ack), 7'd1);
    check("ack_early", 7'(ack_early), 7'd0);
    check("row6_seen", 7'(seen6), 7'd1);
    check("row6_c_old", 7'(c6), 7'd0);
    scan_frame("frame_a");
    check("fa_row0", 7'(cap[0]), 7'b0010101);
    check("fa_row6", 7'(cap[6]), 7'b0001110);
    en = 1'b0;
    tick();
    check("idle_l", l, 7'h7f);
    check("idle_c", 7'(c), 7'd0);
    write_row(3'd2, 5'b00011);
    wr = 1'b1;
    wr_row = 3'd7;
    wr_data = 5'b11111;
    swap = 1'b1;
    tick();
    swap = 1'b0;
    wr_row = 3'd2;
    wr_data = 5'b11000;
    tick();
    wr = 1'b0;
    check("ack_same_edge", 7'(swap_ack), 7'd1);
    en = 1'b1;
    scan_frame("frame_b");
    check("fb_row0", 7'(cap[0]), 7'b0010101);
    check("fb_row1", 7'(cap[1]), 7'd0);
    check("fb_row2_old", 7'(cap[2]), 7'b0000011);
    check("fb_row3", 7'(cap[3]), 7'd0);
    check("fb_row4", 7'(cap[4]), 7'd0);
    check("fb_row5", 7'(cap[5]), 7'd0);
    check("fb_row6", 7'(cap[6]), 7'b0001110);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    scan_frame("frame_c");
    check("fc_row2_new", 7'(cap[2]), 7'b0011000);
    check("fc_row0", 7'(cap[0]), 7'b0010101);
    k = 0;
    while (l != 7'b1110111 && k < 100) begin
      tick();
      k++;
    end
    check("row3_reached", l, 7'b1110111);
    en = 1'b0;
    tick();
    check("drop_l", l, 7'h7f);
    check("drop_c", 7'(c), 7'd0);
    tick();
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reen_blank_l", l, 7'h7f);
    end
    tick();
    check("reen_drv_l", l, 7'b1111110);
    check("reen_drv_c", 7'(c), 7'b0010101);
`ifdef MATRIZ_PWM_EN
    duty = 3'd3;
    for (int i = 0; i < 56; i++) begin
      tick();
      if (l == 7'b1111110) check("pwm3_c", 7'(c), pwm_m <= 3'd3 ? 7'b0010101 : 7'd0);
    end
    duty = 3'd7;
    for (int i = 0; i < 56; i++) begin
      tick();
      if (l == 7'b1111110) check("pwm7_c", 7'(c), 7'b0010101);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
